// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default widths and the hard-wired zero register predicate
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PEND_W = 2;
    function automatic logic is_zero_reg(input int zr, input int unsigned r);
        return (zr != 0) && (r == 0);
    endfunction
endpackage

// File: rtl/regfile_bypass_scoreboard_if.sv
// regfile_bypass_scoreboard_if: decode/writeback bus of the register file
// master: decode + writeback side (drives addresses, writes, issues, flush)
// slave:  register file (returns read data, busy flags, issue_stall, sb_err)
interface regfile_bypass_scoreboard_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);
    logic [ADDR_W-1:0]        rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic signed [DATA_W-1:0] rd_data1, rd_data2;
    logic [DATA_W-1:0]        wr_data;
    logic                     rd_busy1, rd_busy2, wr_en, issue_en, issue_stall, flush, sb_err;
    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, issue_stall, sb_err
    );
    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, issue_stall, sb_err
    );
endinterface

// File: rtl/pend_counter.sv
// pend_counter: saturating pending-write counter for one register
// inc_i/dec_i: issue/retire, clr_i: flush; nonzero_o, full_o, underflow_o (retire on empty)
module pend_counter #(
    parameter int PEND_W = regfile_pkg::PEND_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic nonzero_o,
    output logic full_o,
    output logic underflow_o
);
    logic [PEND_W-1:0] cnt_q, cnt_d;
    assign nonzero_o   = |cnt_q;
    assign full_o      = &cnt_q;
    assign underflow_o = dec_i && !inc_i && !nonzero_o;
    always_comb
        cnt_d = clr_i                          ? '0 :
                (inc_i && !dec_i && !full_o)   ? cnt_q + 1'b1 :
                (dec_i && !inc_i && nonzero_o) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk)
        cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/regfile_bypass_scoreboard.sv
// regfile_bypass_scoreboard: dual-read register file with write bypass and RAW scoreboard
// clk/rst: clock and sync active-high reset; rf: slave side of the decode/writeback bus
module regfile_bypass_scoreboard #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int PEND_W   = regfile_pkg::PEND_W,
    parameter int ZERO_REG = 1
) (
    input logic clk,
    input logic rst,
    regfile_bypass_scoreboard_if.slave rf
);
    import regfile_pkg::*;
    localparam int NUM_REGS = 2 ** ADDR_W;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] nz, full, uf;
    logic                sb_err_q, sb_err_d;
    assign rf.rd_data1 = is_zero_reg(ZERO_REG, 32'(rf.rd_addr1)) ? '0 :
                         (rf.wr_en && rf.wr_addr == rf.rd_addr1) ? rf.wr_data : regs_q[rf.rd_addr1];
    assign rf.rd_data2 = is_zero_reg(ZERO_REG, 32'(rf.rd_addr2)) ? '0 :
                         (rf.wr_en && rf.wr_addr == rf.rd_addr2) ? rf.wr_data : regs_q[rf.rd_addr2];
    // zero register never increments, so its counter stays at 0 and busy reads low
    assign rf.rd_busy1    = nz[rf.rd_addr1];
    assign rf.rd_busy2    = nz[rf.rd_addr2];
    assign rf.issue_stall = rf.issue_en && full[rf.issue_addr];
    assign rf.sb_err      = sb_err_q;
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam bit Z = is_zero_reg(ZERO_REG, r);
        pend_counter #(.PEND_W(PEND_W)) u_pend (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (!Z && rf.issue_en && !rf.issue_stall && rf.issue_addr == ADDR_W'(r)),
            .dec_i       (!Z && rf.wr_en && rf.wr_addr == ADDR_W'(r)),
            .clr_i       (rf.flush),
            .nonzero_o   (nz[r]),
            .full_o      (full[r]),
            .underflow_o (uf[r])
        );
    end
    always_comb sb_err_d = sb_err_q || (|uf);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            if (rf.wr_en && !is_zero_reg(ZERO_REG, 32'(rf.wr_addr))) regs_q[rf.wr_addr] <= rf.wr_data;
            sb_err_q <= sb_err_d;
        end
    end
endmodule

// File: tb/tb_regfile_bypass_scoreboard.sv
// tb_regfile_bypass_scoreboard: directed plan plus random traffic against a reference model
module tb_regfile_bypass_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    regfile_bypass_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_bypass_scoreboard #(.DATA_W(32), .ADDR_W(5), .PEND_W(2), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );
    int          n_chk = 0, n_fail = 0;
    logic [31:0] mreg [32];
    int          mpend [32];
    bit          merr;
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] exp_rd(logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return mreg[a];
    endfunction
    function automatic logic exp_busy(logic [4:0] a);
        return a != 0 && mpend[a] > 0;
    endfunction
    function automatic logic exp_stall();
        return bus.issue_en && mpend[bus.issue_addr] == 3;
    endfunction
    task automatic drive(bit we, int wa, logic [31:0] wd, bit ie, int ia, bit fl);
        bus.wr_en = we; bus.wr_addr = 5'(wa); bus.wr_data = wd;
        bus.issue_en = ie; bus.issue_addr = 5'(ia); bus.flush = fl;
    endtask
    task automatic rd(int a1, int a2);
        bus.rd_addr1 = 5'(a1); bus.rd_addr2 = 5'(a2);
    endtask
    task automatic tick();
        bit st, inc, dec;
        int wa, ia;
        @(negedge clk);
        if (!rst) begin
            check("rd_data1", bus.rd_data1, exp_rd(bus.rd_addr1));
            check("rd_data2", bus.rd_data2, exp_rd(bus.rd_addr2));
            check("rd_busy1", 32'(bus.rd_busy1), 32'(exp_busy(bus.rd_addr1)));
            check("rd_busy2", 32'(bus.rd_busy2), 32'(exp_busy(bus.rd_addr2)));
            check("issue_stall", 32'(bus.issue_stall), 32'(exp_stall()));
            check("sb_err", 32'(bus.sb_err), 32'(merr));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin mreg[i] = 0; mpend[i] = 0; end
            merr = 0;
        end else begin
            st  = exp_stall();
            wa  = int'(bus.wr_addr);
            ia  = int'(bus.issue_addr);
            inc = bus.issue_en && !st && ia != 0;
            dec = bus.wr_en && wa != 0;
            if (dec) mreg[wa] = bus.wr_data;
            if (dec && mpend[wa] == 0 && !(inc && ia == wa)) merr = 1;
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) mpend[i] = 0;
            end else begin
                if (inc) mpend[ia]++;
                if (dec && mpend[wa] > 0) mpend[wa]--;
            end
        end
        #1;
    endtask
    initial begin
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0); rd(0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin drive(1, i, 32'hFFFF_FFFF, 0, 0, 0); tick(); end
        drive(0, 0, 0, 0, 0, 0); rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 32; i++) begin rd(i, 31 - i); tick(); end
        rd(5, 0); drive(1, 5, 32'h1234, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 32'h7, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        rd(3, 0); drive(0, 0, 0, 1, 3, 0); tick(); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 3, 32'h33, 0, 0, 0); tick();
        drive(1, 3, 32'h34, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 3, 32'h35, 1, 3, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        rd(9, 3); drive(0, 0, 0, 1, 9, 0); tick(); tick(); tick(); tick();
        drive(1, 9, 32'h99, 1, 9, 0); tick();
        drive(0, 0, 0, 1, 9, 0); tick(); tick();
        drive(1, 9, 32'h98, 0, 0, 0); tick(); tick(); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        rd(7, 9); drive(1, 7, 32'h77, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        rd(4, 2); drive(0, 0, 0, 1, 2, 0); tick();
        drive(0, 0, 0, 1, 4, 0); tick(); tick(); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 4, 32'hAA, 1, 6, 1); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        rd(6, 4); tick();
        for (int c = 0; c < 800; c++) begin
            int wa, ia;
            wa = $urandom_range(0, 7);
            ia = $urandom_range(0, 7);
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 4, wa, $urandom, $urandom_range(0, 9) < 6, ia,
                  $urandom_range(0, 19) == 0);
            rd($urandom_range(0, 1) ? wa : $urandom_range(0, 7), $urandom_range(0, 1) ? ia : $urandom_range(0, 31));
            tick();
        end
        rst = 1'b0; drive(0, 0, 0, 0, 0, 0); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
